// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the HEX display scheduler.
//   disp_state_t : scheduler FSM states
//   src_t        : which requester owns the currently latched content
//   HEX_DASH     : active-low segment pattern for '-' (only segment g lit)
//   HEX_BLANK    : active-low pattern with every segment and DP off
package hex_disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        BUSY = 2'd2
    } disp_state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_RES  = 2'd1,
        SRC_DBG  = 2'd2
    } src_t;

    localparam logic [7:0] HEX_DASH  = 8'hBF;
    localparam logic [7:0] HEX_BLANK = 8'hFF;

endpackage

// File: rtl/hex_driver.sv
// Single-digit seven-segment encoder (active-low, DP off).
// Ports:
//   In0  in  4  nibble to display (0-F)
//   dash in  1  1 = show '-' instead of the nibble
//   hex  out 8  active-low segments {dp,g,f,e,d,c,b,a}; bit 7 always 1
module hex_driver
    import hex_disp_pkg::*;
(
    input  logic [3:0] In0,
    input  logic       dash,
    output logic [7:0] hex
);

    logic [7:0] seg;

    always_comb begin
        seg = HEX_BLANK;
        unique case (In0)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
            default: seg = HEX_BLANK;
        endcase
    end

    assign hex = dash ? HEX_DASH : seg;

endmodule

// File: rtl/hex_display_sched.sv
// Arbitrates the board's seven-segment digits between the NN result path
// (high priority) and the debug/status path (low priority). Accepted content
// is held for at least HOLD_CYCLES; while busy is high every digit blinks a dash.
//
// state | meaning
// IDLE  | show latched content, accept a new request
// HOLD  | show latched content, hold counter running; only a result may
//       | preempt, and only when the held content came from debug
// BUSY  | inference running, all digits blink dash / blank
//
// Ports:
//   Clk, Reset             clock (rising edge), async active-high reset
//   busy                   inference in progress
//   res_valid/ready/value/dash   result request (nibble per digit, digit 0 = [3:0])
//   dbg_valid/ready/value/dash   debug request, same layout, low priority
//   HEX                    active-low segments, digit i = [8i+7:8i], DP always 1
//   hold_active            1 while in HOLD
module hex_display_sched
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 6,
    parameter int HOLD_CYCLES  = 50_000_000,
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      busy,
    input  logic                      res_valid,
    output logic                      res_ready,
    input  logic [4*NUM_DIGITS-1:0]   res_value,
    input  logic [NUM_DIGITS-1:0]     res_dash,
    input  logic                      dbg_valid,
    output logic                      dbg_ready,
    input  logic [4*NUM_DIGITS-1:0]   dbg_value,
    input  logic [NUM_DIGITS-1:0]     dbg_dash,
    output logic [8*NUM_DIGITS-1:0]   HEX,
    output logic                      hold_active
);

    localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    disp_state_t                state;
    src_t                       src;
    logic [4*NUM_DIGITS-1:0]    disp_value;
    logic [NUM_DIGITS-1:0]      disp_dash;
    logic [HOLD_W-1:0]          hold_cnt;
    logic [BLINK_W-1:0]         blink_cnt;
    logic                       blink_on;

    logic res_fire;
    logic dbg_fire;

    // Readys are combinational so a request is accepted on the edge it is seen.
    assign res_ready = !busy && ((state == IDLE) || (state == HOLD && src == SRC_DBG));
    assign dbg_ready = !busy && (state == IDLE) && !res_valid;
    assign res_fire  = res_valid && res_ready;
    assign dbg_fire  = dbg_valid && dbg_ready;

    assign hold_active = (state == HOLD);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            src        <= SRC_NONE;
            disp_value <= '0;
            disp_dash  <= '1;
            hold_cnt   <= '0;
            blink_cnt  <= '0;
            blink_on   <= 1'b1;
        end else begin
            unique case (state)
                IDLE, HOLD: begin
                    if (busy) begin
                        // Hold is abandoned, latched content survives for after busy.
                        state     <= BUSY;
                        hold_cnt  <= '0;
                        blink_cnt <= '0;
                        blink_on  <= 1'b1;
                    end else if (res_fire) begin
                        state      <= HOLD;
                        src        <= SRC_RES;
                        disp_value <= res_value;
                        disp_dash  <= res_dash;
                        hold_cnt   <= '0;
                    end else if (dbg_fire) begin
                        state      <= HOLD;
                        src        <= SRC_DBG;
                        disp_value <= dbg_value;
                        disp_dash  <= dbg_dash;
                        hold_cnt   <= '0;
                    end else if (state == HOLD) begin
                        if (hold_cnt == HOLD_LAST) begin
                            state    <= IDLE;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (!busy) begin
                        state <= IDLE;
                    end else if (blink_cnt == BLINK_LAST) begin
                        blink_cnt <= '0;
                        blink_on  <= !blink_on;
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    logic busy_dash;
    logic busy_blank;

    assign busy_dash  = (state == BUSY) && blink_on;
    assign busy_blank = (state == BUSY) && !blink_on;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        logic [7:0] digit_hex;

        hex_driver u_hex_driver (
            .In0  (disp_value[4*i +: 4]),
            .dash (disp_dash[i] | busy_dash),
            .hex  (digit_hex)
        );

        assign HEX[8*i +: 8] = busy_blank ? HEX_BLANK : digit_hex;
    end

endmodule

// File: tb/tb_hex_display_sched.sv
module tb_hex_display_sched;

    localparam int ND = 6;

    logic           Clk;
    logic           Reset;
    logic           busy;
    logic           res_valid;
    logic           res_ready;
    logic [23:0]    res_value;
    logic [5:0]     res_dash;
    logic           dbg_valid;
    logic           dbg_ready;
    logic [23:0]    dbg_value;
    logic [5:0]     dbg_dash;
    logic [47:0]    HEX;
    logic           hold_active;

    int checks = 0;
    int errors = 0;

    hex_display_sched #(
        .NUM_DIGITS   (ND),
        .HOLD_CYCLES  (4),
        .BLINK_CYCLES (2)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_value   (res_value),
        .res_dash    (res_dash),
        .dbg_valid   (dbg_valid),
        .dbg_ready   (dbg_ready),
        .dbg_value   (dbg_value),
        .dbg_dash    (dbg_dash),
        .HEX         (HEX),
        .hold_active (hold_active)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    localparam logic [47:0] ALL_DASH  = {6{8'hBF}};
    localparam logic [47:0] ALL_BLANK = {6{8'hFF}};
    localparam logic [47:0] ALL_ZERO  = {6{8'hC0}};

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        busy = 1'b0;
        res_valid = 1'b0; res_value = '0; res_dash = '0;
        dbg_valid = 1'b0; dbg_value = '0; dbg_dash = '0;
        tick(); tick();
        Reset = 1'b0;
        #1;
        checks++; if (HEX !== ALL_DASH) begin errors++; $display("FAIL reset_hex: got %h expected %h", HEX, ALL_DASH); end
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL reset_res_ready: got %b expected 1", res_ready); end
        checks++; if (dbg_ready !== 1'b1) begin errors++; $display("FAIL reset_dbg_ready: got %b expected 1", dbg_ready); end
        checks++; if (hold_active !== 1'b0) begin errors++; $display("FAIL reset_hold_active: got %b expected 0", hold_active); end
    endtask

    task automatic test_result_hold();
        logic [47:0] exp;
        exp = {{5{8'hBF}}, 8'hF8};
        res_valid = 1'b1; res_value = 24'h000007; res_dash = 6'b111110;
        #1;
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL hold_ready_pre: got %b expected 1", res_ready); end
        tick();
        res_valid = 1'b0;
        #1;
        checks++; if (HEX !== exp) begin errors++; $display("FAIL hold_hex: got %h expected %h", HEX, exp); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (hold_active !== 1'b1) begin errors++; $display("FAIL hold_active_cycle%0d: got %b expected 1", i, hold_active); end
            checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL hold_res_ready_cycle%0d: got %b expected 0", i, res_ready); end
            if (i < 3) tick();
        end
        tick();
        checks++; if (hold_active !== 1'b0) begin errors++; $display("FAIL hold_end_active: got %b expected 0", hold_active); end
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL hold_end_ready: got %b expected 1", res_ready); end
        checks++; if (HEX !== exp) begin errors++; $display("FAIL hold_end_hex: got %h expected %h", HEX, exp); end
    endtask

    task automatic test_priority();
        logic [47:0] exp;
        exp = {{5{8'hBF}}, 8'hA4};
        res_valid = 1'b1; res_value = 24'h000002; res_dash = 6'b111110;
        dbg_valid = 1'b1; dbg_value = 24'h000000; dbg_dash = 6'b000000;
        #1;
        checks++; if (dbg_ready !== 1'b0) begin errors++; $display("FAIL prio_dbg_ready: got %b expected 0", dbg_ready); end
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL prio_res_ready: got %b expected 1", res_ready); end
        tick();
        res_valid = 1'b0;
        #1;
        checks++; if (HEX !== exp) begin errors++; $display("FAIL prio_res_hex: got %h expected %h", HEX, exp); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (dbg_ready !== 1'b0) begin errors++; $display("FAIL prio_dbg_blocked%0d: got %b expected 0", i, dbg_ready); end
            tick();
        end
        checks++; if (dbg_ready !== 1'b0) begin errors++; $display("FAIL prio_dbg_blocked3: got %b expected 0", dbg_ready); end
        tick();
        checks++; if (dbg_ready !== 1'b1) begin errors++; $display("FAIL prio_dbg_idle_ready: got %b expected 1", dbg_ready); end
        checks++; if (hold_active !== 1'b0) begin errors++; $display("FAIL prio_idle_active: got %b expected 0", hold_active); end
        tick();
        dbg_valid = 1'b0;
        #1;
        checks++; if (HEX !== ALL_ZERO) begin errors++; $display("FAIL prio_dbg_hex: got %h expected %h", HEX, ALL_ZERO); end
        checks++; if (hold_active !== 1'b1) begin errors++; $display("FAIL prio_dbg_active: got %b expected 1", hold_active); end
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL prio_dbg_hold_res_ready: got %b expected 1", res_ready); end
    endtask

    // Runs straight after test_priority: debug content is held, hold_cnt=0.
    task automatic test_preempt();
        logic [47:0] exp;
        exp = {{5{8'hBF}}, 8'hF9};
        tick(); tick();
        res_valid = 1'b1; res_value = 24'h000001; res_dash = 6'b111110;
        #1;
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL preempt_ready: got %b expected 1", res_ready); end
        tick();
        res_valid = 1'b0;
        #1;
        checks++; if (HEX !== exp) begin errors++; $display("FAIL preempt_hex: got %h expected %h", HEX, exp); end
        checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL preempt_no_repreempt: got %b expected 0", res_ready); end
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++; if (hold_active !== 1'b1) begin errors++; $display("FAIL preempt_full_hold%0d: got %b expected 1", i, hold_active); end
        end
        tick();
        checks++; if (hold_active !== 1'b0) begin errors++; $display("FAIL preempt_hold_end: got %b expected 0", hold_active); end
    endtask

    task automatic test_busy_blink();
        logic [47:0] content;
        logic [7:0]  pat [5];
        content = {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82};
        pat[0] = 8'hBF; pat[1] = 8'hBF; pat[2] = 8'hFF; pat[3] = 8'hFF; pat[4] = 8'hBF;
        res_valid = 1'b1; res_value = 24'h123456; res_dash = 6'b000000;
        tick();
        res_valid = 1'b0;
        #1;
        checks++; if (HEX !== content) begin errors++; $display("FAIL busy_content: got %h expected %h", HEX, content); end
        tick();
        busy = 1'b1;
        res_valid = 1'b1; res_value = 24'h000000;
        dbg_valid = 1'b1;
        #1;
        checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL busy_res_ready: got %b expected 0", res_ready); end
        checks++; if (dbg_ready !== 1'b0) begin errors++; $display("FAIL busy_dbg_ready: got %b expected 0", dbg_ready); end
        for (int i = 0; i < 5; i++) begin
            logic [47:0] e;
            tick();
            e = {6{pat[i]}};
            checks++; if (HEX !== e) begin errors++; $display("FAIL busy_blink%0d: got %h expected %h", i, HEX, e); end
            checks++; if (hold_active !== 1'b0) begin errors++; $display("FAIL busy_hold_active%0d: got %b expected 0", i, hold_active); end
        end
        busy = 1'b0;
        res_valid = 1'b0;
        dbg_valid = 1'b0;
        tick();
        checks++; if (HEX !== content) begin errors++; $display("FAIL busy_restore_hex: got %h expected %h", HEX, content); end
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL busy_restore_ready: got %b expected 1", res_ready); end
        checks++; if (hold_active !== 1'b0) begin errors++; $display("FAIL busy_restore_active: got %b expected 0", hold_active); end
    endtask

    task automatic test_reset_mid_hold();
        logic [47:0] exp;
        exp = {8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        res_valid = 1'b1; res_value = 24'hABCDEF; res_dash = 6'b000000;
        tick();
        res_valid = 1'b0;
        #1;
        checks++; if (HEX !== exp) begin errors++; $display("FAIL rst_pre_hex: got %h expected %h", HEX, exp); end
        tick();
        #2;
        Reset = 1'b1;
        res_valid = 1'b1; res_value = 24'h000000;
        #1;
        checks++; if (HEX !== ALL_DASH) begin errors++; $display("FAIL rst_async_hex: got %h expected %h", HEX, ALL_DASH); end
        checks++; if (hold_active !== 1'b0) begin errors++; $display("FAIL rst_async_active: got %b expected 0", hold_active); end
        tick();
        res_valid = 1'b0;
        Reset = 1'b0;
        tick();
        checks++; if (HEX !== ALL_DASH) begin errors++; $display("FAIL rst_dropped_hex: got %h expected %h", HEX, ALL_DASH); end
        checks++; if (hold_active !== 1'b0) begin errors++; $display("FAIL rst_dropped_active: got %b expected 0", hold_active); end
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL rst_dropped_ready: got %b expected 1", res_ready); end
    endtask

    initial begin
        test_reset();
        test_result_hold();
        test_priority();
        test_preempt();
        test_busy_blink();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
